// File: rtl/rr_ingress_pkg.sv
// ----------------------------------------------------------------------------
// rr_ingress_pkg
//   Shared constants, source-port encodings and small grant-vector helpers for
//   the three-port ingress buffer that feeds the round-robin arbiter.
//
//   Contents:
//     NPORT        number of requester ports (3)
//     SRC_W        width of the source tag carried with output data
//     src_e        source-port encodings SRC_P0..SRC_P2
//     src_of()     port index -> source tag
//     is_onehot()  exactly one bit set
//     is_multihot() two or more bits set
// ----------------------------------------------------------------------------
package rr_ingress_pkg;

   localparam int NPORT = 3;
   localparam int SRC_W = 2;

   typedef enum logic [SRC_W-1:0] {
      SRC_P0 = 2'd0,
      SRC_P1 = 2'd1,
      SRC_P2 = 2'd2
   } src_e;

   function automatic logic [SRC_W-1:0] src_of(input int unsigned idx);
      case (idx)
         0:       return SRC_P0;
         1:       return SRC_P1;
         default: return SRC_P2;
      endcase
   endfunction

   // v & (v - 1) clears the lowest set bit; anything left means >= 2 bits set.
   function automatic logic is_multihot(input logic [NPORT-1:0] v);
      logic [NPORT-1:0] m;
      m = v - NPORT'(1);
      return ((v & m) != '0);
   endfunction

   function automatic logic is_onehot(input logic [NPORT-1:0] v);
      return (v != '0) && !is_multihot(v);
   endfunction

endpackage

// File: rtl/rr_ingress_mux_fifo.sv
// ----------------------------------------------------------------------------
// rr_port_fifo
//   Small synchronous FIFO holding one requester's words until the arbiter
//   grants that port. Head data is presented combinationally (first-word
//   fall-through), so a pop in cycle N delivers head at edge N+1.
//
//   Parameters:
//     DW     data width
//     DEPTH  entries, power of 2, >= 2
//
//   Ports:
//     clk, rstn   clock, asynchronous active-low reset (pointers/count only)
//     push        write push_data; ignored when full
//     push_data   write data
//     pop         advance head; ignored when empty
//     cnt         occupancy, 0..DEPTH
//     head        data at the read pointer (valid when !empty)
//     full        cnt == DEPTH
//     empty       cnt == 0
// ----------------------------------------------------------------------------
module rr_port_fifo
   import rr_ingress_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic          push,
   input  logic [DW-1:0] push_data,
   input  logic          pop,
   output logic [CW-1:0] cnt,
   output logic [DW-1:0] head,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          push_ok;
   logic          pop_ok;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign cnt     = cnt_q;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         // Simultaneous push and pop leave the count unchanged.
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage is not reset: contents are only observable through a valid count.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/rr_ingress_mux.sv
// ----------------------------------------------------------------------------
// rr_ingress_mux
//   Three-port ingress buffer and data mux around an external 3-way
//   round-robin arbiter. Each port's words are queued in an rr_port_fifo; the
//   non-empty FIFOs raise arb_req, and the arbiter's registered one-hot grant
//   pops the winner into a single output register tagged with its source port.
//
//   Handshakes (all interfaces): a word moves on a rising clk edge when
//   valid and ready are both high in the cycle before it. Valid never depends
//   on ready in the same cycle. in_rdy is purely a FIFO-space indication and is
//   not raised by a pop in the same cycle. Once out_vld is high, out_data and
//   out_src hold until out_rdy accepts them.
//
//   Parameters:
//     DW     data width per port
//     DEPTH  per-port FIFO depth (power of 2, >= 2)
//
//   Ports:
//     clk, rstn   clock, asynchronous active-low reset
//     in_vld      per-port write valid, bit i = port i
//     in_data     per-port data, port i at [i*DW +: DW]
//     in_rdy      per-port write ready (FIFO not full)
//     arb_req     request vector to arbiter
//     arb_en      enable to arbiter, set on first edge after reset release
//     arb_grant   one-hot grant from arbiter, one cycle after arb_req
//     out_vld     output data valid
//     out_data    output data
//     out_src     source port of out_data
//     out_rdy     downstream ready
//     gnt_err     sticky: a qualified grant had more than one bit set
// ----------------------------------------------------------------------------
module rr_ingress_mux
   import rr_ingress_pkg::*;
#(
   parameter int DW    = 8,
   parameter int DEPTH = 4
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [NPORT-1:0]    in_vld,
   input  logic [NPORT*DW-1:0] in_data,
   output logic [NPORT-1:0]    in_rdy,
   output logic [NPORT-1:0]    arb_req,
   output logic                arb_en,
   input  logic [NPORT-1:0]    arb_grant,
   output logic                out_vld,
   output logic [DW-1:0]       out_data,
   output logic [SRC_W-1:0]    out_src,
   input  logic                out_rdy,
   output logic                gnt_err
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [CW-1:0]    cnt  [NPORT];
   logic [DW-1:0]    head [NPORT];
   logic [NPORT-1:0] full;
   logic [NPORT-1:0] empty;
   logic [NPORT-1:0] push;
   logic [NPORT-1:0] pop;

   logic             gnt_qual;
   logic             stall;
   logic             gnt_onehot;
   logic             gnt_multi;
   logic             pop_any;
   logic [DW-1:0]    sel_data;
   logic [SRC_W-1:0] sel_src;

   // ------------------------------------------------------------------------
   // Per-port FIFOs
   // ------------------------------------------------------------------------
   for (genvar i = 0; i < NPORT; i++) begin : g_port
      rr_port_fifo #(
         .DW    (DW),
         .DEPTH (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rstn      (rstn),
         .push      (push[i]),
         .push_data (in_data[i*DW +: DW]),
         .pop       (pop[i]),
         .cnt       (cnt[i]),
         .head      (head[i]),
         .full      (full[i]),
         .empty     (empty[i])
      );
   end

   // ------------------------------------------------------------------------
   // Arbiter enable and grant qualification
   //   The arbiter may come out of reset later than this block, so its grant
   //   is only trusted one cycle after it has seen en = 1.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         arb_en   <= 1'b0;
         gnt_qual <= 1'b0;
      end else begin
         arb_en   <= 1'b1;
         gnt_qual <= arb_en;
      end
   end

   assign stall      = out_vld & ~out_rdy;
   assign gnt_onehot = is_onehot(arb_grant);
   assign gnt_multi  = gnt_qual & is_multihot(arb_grant);

   // ------------------------------------------------------------------------
   // Push / pop
   //   A grant that lands on a stall or an empty FIFO is simply dropped; the
   //   arbiter will see the request again and re-grant later.
   // ------------------------------------------------------------------------
   always_comb begin
      in_rdy = '0;
      push   = '0;
      pop    = '0;
      for (int i = 0; i < NPORT; i++) begin
         in_rdy[i] = ~full[i];
         push[i]   = in_vld[i] & ~full[i];
         pop[i]    = gnt_qual & arb_grant[i] & ~empty[i] & ~stall & gnt_onehot;
      end
   end

   // ------------------------------------------------------------------------
   // Requests
   //   An entry being popped this cycle is not requested again, otherwise the
   //   arbiter could grant a word that has already left the FIFO.
   // ------------------------------------------------------------------------
   always_comb begin
      arb_req = '0;
      for (int i = 0; i < NPORT; i++) begin
         arb_req[i] = (cnt[i] > CW'(pop[i])) & ~stall;
      end
   end

   // ------------------------------------------------------------------------
   // Output mux (pop is at most one-hot by construction)
   // ------------------------------------------------------------------------
   always_comb begin
      pop_any  = |pop;
      sel_data = '0;
      sel_src  = '0;
      for (int i = 0; i < NPORT; i++) begin
         if (pop[i]) begin
            sel_data = head[i];
            sel_src  = src_of(i);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Output register
   //   Pops only happen when not stalled, so data/src never change while a
   //   word is waiting for out_rdy.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_vld  <= 1'b0;
         out_data <= '0;
         out_src  <= '0;
      end else if (pop_any) begin
         out_vld  <= 1'b1;
         out_data <= sel_data;
         out_src  <= sel_src;
      end else if (out_vld && out_rdy) begin
         out_vld  <= 1'b0;
      end
   end

   // ------------------------------------------------------------------------
   // Sticky grant error
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gnt_err <= 1'b0;
      end else if (gnt_multi) begin
         gnt_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rr_ingress_mux.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_rr_ingress_mux
//   Bench for rr_ingress_mux with a behavioural round-robin arbiter (registered
//   grant, one cycle behind arb_req, holding a garbage grant until it is
//   enabled). Inputs change #1 after the rising edge; outputs are compared on
//   the falling edge.
// ----------------------------------------------------------------------------
module tb_rr_ingress_mux;

   localparam int DW    = 8;
   localparam int DEPTH = 4;
   localparam int NP    = 3;

   // ---------------------------------------------------------------- clock/reset
   logic clk  = 1'b0;
   logic rstn = 1'b0;
   always #5 clk = ~clk;

   logic [NP-1:0]    in_vld  = '0;
   logic [NP*DW-1:0] in_data = '0;
   logic [NP-1:0]    in_rdy;
   logic [NP-1:0]    arb_req;
   logic             arb_en;
   logic [NP-1:0]    arb_grant;
   logic             out_vld;
   logic [DW-1:0]    out_data;
   logic [1:0]       out_src;
   logic             out_rdy = 1'b1;
   logic             gnt_err;

   rr_ingress_mux #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_vld    (in_vld),
      .in_data   (in_data),
      .in_rdy    (in_rdy),
      .arb_req   (arb_req),
      .arb_en    (arb_en),
      .arb_grant (arb_grant),
      .out_vld   (out_vld),
      .out_data  (out_data),
      .out_src   (out_src),
      .out_rdy   (out_rdy),
      .gnt_err   (gnt_err)
   );

   // ---------------------------------------------------------------- arbiter model
   logic [NP-1:0] grant_q    = 3'b111;   // un-reset arbiter: garbage grant
   int            rr_last    = 2;
   logic          force_mode = 1'b0;
   logic [NP-1:0] force_val  = '0;
   logic [NP-1:0] g_nxt;

   function automatic logic [NP-1:0] rr_pick(input logic [NP-1:0] req, input int last);
      logic [NP-1:0] g;
      g = '0;
      for (int k = 1; k <= NP; k++) begin
         int idx;
         idx = (last + k) % NP;
         if (g == '0 && req[idx]) g[idx] = 1'b1;
      end
      return g;
   endfunction

   assign g_nxt     = rr_pick(arb_req, rr_last);
   assign arb_grant = grant_q;

   always @(posedge clk) begin
      if (force_mode) begin
         grant_q <= force_val;
      end else if (arb_en) begin
         grant_q <= g_nxt;
         if (g_nxt[0])      rr_last <= 0;
         else if (g_nxt[1]) rr_last <= 1;
         else if (g_nxt[2]) rr_last <= 2;
      end
   end

   // ---------------------------------------------------------------- scoreboard
   int             tests_run    = 0;
   int             tests_failed = 0;
   int             n_out        = 0;
   int             mon_idx;
   logic [DW+1:0]  exp_q[$];            // {src, data}

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h required %0h", name, act, exp);
      end
   endtask

   // Per-port ordering: each output must match the oldest pending word of its source.
   always @(negedge clk) begin
      if (rstn && out_vld && out_rdy) begin
         tests_run++;
         n_out++;
         mon_idx = -1;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (mon_idx < 0 && exp_q[i][DW+1:DW] == out_src) mon_idx = i;
         end
         if (mon_idx < 0) begin
            tests_failed++;
            $display("FAIL out_unexpected: got src %0d data %0h required no output", out_src, out_data);
         end else begin
            if (exp_q[mon_idx][DW-1:0] !== out_data) begin
               tests_failed++;
               $display("FAIL out_data src%0d: got %0h required %0h", out_src, out_data, exp_q[mon_idx][DW-1:0]);
            end
            exp_q.delete(mon_idx);
         end
      end
   end

   // ---------------------------------------------------------------- driver tasks
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Drive one cycle of writes; every asserted port is expected to be accepted.
   task automatic drive(input logic [NP-1:0] vld, input logic [NP*DW-1:0] data);
      in_vld  = vld;
      in_data = data;
      for (int p = 0; p < NP; p++) begin
         if (vld[p]) exp_q.push_back({2'(p), data[p*DW +: DW]});
      end
   endtask

   task automatic wait_drain(input string name, input int n, input int budget);
      int start;
      int c;
      start = n_out;
      c     = 0;
      while (exp_q.size() != 0 && c < budget) begin
         @(negedge clk);
         #1;
         c++;
      end
      check({name, "_left"}, exp_q.size(), 0);
      check({name, "_count"}, n_out - start, n);
      repeat (3) @(negedge clk);
   endtask

   // ---------------------------------------------------------------- vectors
   typedef struct packed {
      logic [NP-1:0]    vld;
      logic [NP*DW-1:0] data;
      logic             ordy;
      logic [NP-1:0]    e_in_rdy;
      logic [NP-1:0]    e_req;
      logic             e_vld;
      logic [DW-1:0]    e_data;
      logic [1:0]       e_src;
   } vec_t;

   vec_t vecs [5];

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin : main
      // Single port-1 word: accepted at edge N, request N+1, grant/pop N+2, output N+3.
      vecs[0] = '{vld:3'b010, data:24'h00A500, ordy:1'b1, e_in_rdy:3'b111, e_req:3'b000, e_vld:1'b0, e_data:8'h00, e_src:2'd0};
      vecs[1] = '{vld:3'b000, data:24'h000000, ordy:1'b1, e_in_rdy:3'b111, e_req:3'b010, e_vld:1'b0, e_data:8'h00, e_src:2'd0};
      vecs[2] = '{vld:3'b000, data:24'h000000, ordy:1'b1, e_in_rdy:3'b111, e_req:3'b000, e_vld:1'b0, e_data:8'h00, e_src:2'd0};
      vecs[3] = '{vld:3'b000, data:24'h000000, ordy:1'b1, e_in_rdy:3'b111, e_req:3'b000, e_vld:1'b1, e_data:8'hA5, e_src:2'd1};
      vecs[4] = '{vld:3'b000, data:24'h000000, ordy:1'b1, e_in_rdy:3'b111, e_req:3'b000, e_vld:1'b0, e_data:8'h00, e_src:2'd0};

      // ---- reset and release
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_out_vld", out_vld, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_src", out_src, 0);
      check("rst_arb_en", arb_en, 0);
      check("rst_gnt_err", gnt_err, 0);
      rstn = 1'b1;
      #1;
      check("rel_arb_en_pre", arb_en, 0);
      check("rel_in_rdy", in_rdy, 3'b111);
      @(negedge clk);
      check("rel_arb_en_post", arb_en, 1);
      check("rel_arb_req", arb_req, 3'b000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("idle_out_vld", out_vld, 0);
         check("idle_gnt_err", gnt_err, 0);
         check("idle_arb_req", arb_req, 3'b000);
      end

      // ---- table: single word latency
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         in_vld  = vecs[k].vld;
         in_data = vecs[k].data;
         out_rdy = vecs[k].ordy;
         for (int p = 0; p < NP; p++) begin
            if (vecs[k].vld[p] && vecs[k].e_in_rdy[p])
               exp_q.push_back({2'(p), vecs[k].data[p*DW +: DW]});
         end
         @(negedge clk);
         check($sformatf("v%0d_in_rdy", k), in_rdy, vecs[k].e_in_rdy);
         check($sformatf("v%0d_arb_req", k), arb_req, vecs[k].e_req);
         check($sformatf("v%0d_out_vld", k), out_vld, vecs[k].e_vld);
         if (vecs[k].e_vld) begin
            check($sformatf("v%0d_out_data", k), out_data, vecs[k].e_data);
            check($sformatf("v%0d_out_src", k), out_src, vecs[k].e_src);
         end
      end
      wait_drain("single", 0, 10);

      // ---- all three ports, two words each
      next_cycle(); drive(3'b111, {8'h30, 8'h20, 8'h10});
      next_cycle(); drive(3'b111, {8'h31, 8'h21, 8'h11});
      next_cycle(); drive(3'b000, '0);
      wait_drain("three_port", 6, 40);

      // ---- fill port 0 while stalled
      for (int k = 0; k < 5; k++) begin
         next_cycle();
         out_rdy = 1'b0;
         drive(3'b001, {16'h0000, 8'(8'h40 + k)});
         @(negedge clk);
         check($sformatf("fill%0d_in_rdy", k), in_rdy, 3'b111);
      end
      next_cycle();
      in_vld  = 3'b001;            // FIFO full: this word must be refused
      in_data = {16'h0000, 8'hEE};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("full_in_rdy", in_rdy, 3'b110);
         check("stall_out_vld", out_vld, 1);
         check("stall_out_data", out_data, 8'h40);
         check("stall_out_src", out_src, 0);
         check("stall_arb_req", arb_req, 3'b000);
         next_cycle();
         in_vld = 3'b000;
      end
      out_rdy = 1'b1;
      wait_drain("fill_drain", 5, 40);

      // ---- multi-hot grant
      next_cycle();
      force_val  = 3'b000;
      force_mode = 1'b1;
      drive(3'b011, {8'h00, 8'h60, 8'h50});
      next_cycle();
      drive(3'b000, '0);
      force_val = 3'b011;
      @(negedge clk);
      check("mh_req_pre", arb_req, 3'b011);
      check("mh_err_pre", gnt_err, 0);
      next_cycle();
      force_val = 3'b000;
      @(negedge clk);
      check("mh_out_vld_grant", out_vld, 0);
      check("mh_req_grant", arb_req, 3'b011);
      next_cycle();
      @(negedge clk);
      check("mh_err_set", gnt_err, 1);
      check("mh_no_pop", out_vld, 0);
      check("mh_cnt_kept", arb_req, 3'b011);
      next_cycle();
      force_mode = 1'b0;
      wait_drain("mh_drain", 2, 40);
      check("mh_err_sticky", gnt_err, 1);

      // ---- reset mid-operation
      for (int k = 0; k < 3; k++) begin
         next_cycle();
         out_rdy = 1'b0;
         drive(3'b100, {8'(8'h70 + k), 16'h0000});
      end
      next_cycle();
      drive(3'b000, '0);
      @(negedge clk);
      check("mid_out_vld", out_vld, 1);
      check("mid_out_data", out_data, 8'h70);
      check("mid_out_src", out_src, 2);
      #1;
      rstn = 1'b0;
      exp_q.delete();              // everything buffered is discarded
      #1;
      check("arst_out_vld", out_vld, 0);
      check("arst_arb_en", arb_en, 0);
      check("arst_out_data", out_data, 0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rstn    = 1'b1;
      out_rdy = 1'b1;
      #1;
      check("arst_in_rdy", in_rdy, 3'b111);
      check("arst_gnt_err", gnt_err, 0);
      repeat (10) @(negedge clk);
      check("arst_no_stale", n_out, n_out);
      check("arst_idle_vld", out_vld, 0);
      check("arst_idle_req", arb_req, 3'b000);
      next_cycle(); drive(3'b001, {16'h0000, 8'h99});
      next_cycle(); drive(3'b000, '0);
      wait_drain("arst_recover", 1, 20);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
